// File: rtl/tr_pkg.sv
// Shared types and period arithmetic for the step ramp generator.
package tr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DECEL = 2'd2
  } tr_state_e;

  // Target period for a request: zero (stop) and oversize requests map to the slowest period.
  function automatic int unsigned tr_target(input int unsigned n,
                                            input int unsigned start,
                                            input int unsigned pulse_w);
    if ((n == 0) || (n > start)) return start;
    if (n <= pulse_w) return pulse_w + 1;
    return n;
  endfunction

  // One ramp step: move cur toward tgt by at most step.
  function automatic int unsigned tr_ramp(input int unsigned cur,
                                          input int unsigned tgt,
                                          input int unsigned step);
    if (cur > tgt) return ((cur - tgt) > step) ? (cur - step) : tgt;
    return ((tgt - cur) > step) ? (cur + step) : tgt;
  endfunction

endpackage

// File: rtl/tr_tick_div.sv
// Tick counter within the current step period, with period-boundary detect.
module tr_tick_div #(
  parameter int unsigned PW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  input  logic          run,
  input  logic [PW-1:0] period,
  output logic [PW-1:0] tick_nxt_c,
  output logic          boundary_c
);

  logic [PW-1:0] tick_cnt;

  // Boundary on the tick that completes the period; counter parked at zero when not running.
  always_comb begin
    boundary_c = run && trig && (tick_cnt == (period - PW'(1)));
    tick_nxt_c = tick_cnt;
    if (!run || boundary_c) begin
      tick_nxt_c = '0;
    end else if (trig) begin
      tick_nxt_c = tick_cnt + PW'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt <= '0;
    else      tick_cnt <= tick_nxt_c;
  end

endmodule

// File: rtl/tr_step_ramp.sv
// Stepper pulse train generator with linear accel/decel ramp and direction interlock.
module tr_step_ramp
  import tr_pkg::*;
#(
  parameter int unsigned PW           = 12,
  parameter int unsigned START_PERIOD = 250,
  parameter int unsigned RAMP_STEP    = 4,
  parameter int unsigned PULSE_W      = 2,
  parameter int unsigned CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid_trig,
  input  logic          drv_enable_SM,
  input  logic          dir_req,
  input  logic [PW-1:0] N,
  output logic          drv_step,
  output logic          drv_dir,
  output logic          busy,
  output logic [PW-1:0] cur_period,
  output logic [CW-1:0] step_cnt
);

  localparam logic [PW-1:0] START_P = PW'(START_PERIOD);
  localparam logic [PW-1:0] PULSE_P = PW'(PULSE_W);

  tr_state_e     state, state_nxt;
  logic [PW-1:0] cur_period_nxt;
  logic [CW-1:0] step_cnt_nxt;
  logic          dir_nxt;
  logic          step_nxt;
  logic          stop_req;
  logic [PW-1:0] tgt;
  logic [PW-1:0] ramp_period;
  logic [PW-1:0] tick_nxt_c;
  logic          boundary_c;

  tr_tick_div #(.PW(PW)) u_tick_div (
    .clk        (clk),
    .rst        (rst),
    .trig       (data_valid_trig),
    .run        (state != ST_IDLE),
    .period     (cur_period),
    .tick_nxt_c (tick_nxt_c),
    .boundary_c (boundary_c)
  );

  // Next state, ramp update and step pulse; a reversal or stop always ramps down via DECEL.
  always_comb begin
    state_nxt      = state;
    cur_period_nxt = cur_period;
    step_cnt_nxt   = step_cnt;
    dir_nxt        = drv_dir;
    stop_req       = !drv_enable_SM || (N == '0) || (dir_req != drv_dir);
    tgt            = (state == ST_RUN) ? PW'(tr_target(32'(N), START_PERIOD, PULSE_W)) : START_P;
    ramp_period    = PW'(tr_ramp(32'(cur_period), 32'(tgt), RAMP_STEP));

    unique case (state)
      ST_IDLE: begin
        if (drv_enable_SM && (N != '0)) begin
          state_nxt      = ST_RUN;
          dir_nxt        = dir_req;
          step_cnt_nxt   = '0;
          cur_period_nxt = START_P;
        end
      end
      ST_RUN: begin
        if (boundary_c) begin
          step_cnt_nxt   = step_cnt + CW'(1);
          cur_period_nxt = ramp_period;
        end
        if (stop_req) state_nxt = ST_DECEL;
      end
      ST_DECEL: begin
        if (boundary_c) begin
          step_cnt_nxt   = step_cnt + CW'(1);
          cur_period_nxt = ramp_period;
          if (!stop_req)                   state_nxt = ST_RUN;
          else if (cur_period == START_P)  state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    step_nxt = (state_nxt != ST_IDLE) && (tick_nxt_c < PULSE_P);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_period <= START_P;
      step_cnt   <= '0;
      drv_dir    <= 1'b0;
      drv_step   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_period <= cur_period_nxt;
      step_cnt   <= step_cnt_nxt;
      drv_dir    <= dir_nxt;
      drv_step   <= step_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_tr_step_ramp.sv
// Self-checking bench for tr_step_ramp against a period-level behavioural model.
module tb_tr_step_ramp;

  localparam int unsigned PW      = 12;
  localparam int unsigned CW      = 16;
  localparam int          START   = 250;
  localparam int          RAMP    = 4;
  localparam int          PULSE_W = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_valid_trig = 1'b0;
  logic          drv_enable_SM = 1'b0;
  logic          dir_req = 1'b0;
  logic [PW-1:0] N = '0;
  logic          drv_step;
  logic          drv_dir;
  logic          busy;
  logic [PW-1:0] cur_period;
  logic [CW-1:0] step_cnt;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 stopped, 1 cruising/accelerating, 2 ramping down.
  int m_mode, m_ticks, m_per, m_steps;
  int m_dir, m_step, m_busy;

  int trig_div = 5;
  int trig_ph  = 0;
  int tick_acc = 0;
  int prev_step = 0;
  int prev_dir  = 0;
  int obs_q[$];

  tr_step_ramp #(
    .PW(PW), .START_PERIOD(START), .RAMP_STEP(RAMP), .PULSE_W(PULSE_W), .CW(CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_valid_trig (data_valid_trig),
    .drv_enable_SM   (drv_enable_SM),
    .dir_req         (dir_req),
    .N               (N),
    .drv_step        (drv_step),
    .drv_dir         (drv_dir),
    .busy            (busy),
    .cur_period      (cur_period),
    .step_cnt        (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int target_of(input int n);
    if (n == 0) return START;
    if (n < PULSE_W + 1) return PULSE_W + 1;
    if (n > START) return START;
    return n;
  endfunction

  function automatic int approach(input int c, input int t);
    int d;
    d = t - c;
    if (d > RAMP)  d = RAMP;
    if (d < -RAMP) d = -RAMP;
    return c + d;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ticks = 0; m_per = START; m_steps = 0;
    m_dir = 0; m_step = 0; m_busy = 0;
  endtask

  task automatic model_step();
    int  tgt;
    int  nmode;
    bit  leave;
    if (!rst) begin
      model_reset();
      return;
    end
    nmode = m_mode;
    if (m_mode == 0) begin
      if (drv_enable_SM && (N != 0)) begin
        nmode = 1; m_dir = int'(dir_req); m_ticks = 0; m_steps = 0; m_per = START;
      end
    end else begin
      leave = !drv_enable_SM || (N == 0) || (int'(dir_req) != m_dir);
      tgt   = (m_mode == 1) ? target_of(int'(N)) : START;
      if (m_mode == 1 && leave) nmode = 2;
      if (data_valid_trig) begin
        m_ticks++;
        if (m_ticks == m_per) begin
          m_ticks = 0;
          m_steps = (m_steps + 1) % 65536;
          if (m_mode == 2) begin
            if (!leave) nmode = 1;
            else if (m_per == START) nmode = 0;
          end
          m_per = approach(m_per, tgt);
        end
      end
    end
    m_mode = nmode;
    m_busy = (m_mode != 0) ? 1 : 0;
    m_step = (m_busy == 1 && m_ticks < PULSE_W) ? 1 : 0;
  endtask

  // One clock: update model at the edge, compare just after it, then schedule the next trig.
  task automatic cycle();
    @(posedge clk);
    if (data_valid_trig) tick_acc++;
    model_step();
    #1;
    check_eq("drv_step",   int'(drv_step),   m_step);
    check_eq("drv_dir",    int'(drv_dir),    m_dir);
    check_eq("busy",       int'(busy),       m_busy);
    check_eq("cur_period", int'(cur_period), m_per);
    check_eq("step_cnt",   int'(step_cnt),   m_steps);
    if (rst && (int'(drv_dir) != prev_dir)) check_eq("dir_change_during_step", prev_step, 0);
    if (drv_step && prev_step == 0) begin
      obs_q.push_back(tick_acc);
      tick_acc = 0;
    end
    prev_step = int'(drv_step);
    prev_dir  = int'(drv_dir);
    if (trig_div == 0) data_valid_trig = ($urandom_range(0, 1) == 1);
    else begin
      data_valid_trig = ((trig_ph % trig_div) == 0);
      trig_ph++;
    end
  endtask

  task automatic run_until_obs(input int n, input int budget, input string tag);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin cycle(); c++; end
    if (obs_q.size() < n) check_eq(tag, obs_q.size(), n);
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int c = 0;
    cycle();
    while (busy && c < budget) begin cycle(); c++; end
    if (busy) check_eq(tag, int'(busy), 0);
  endtask

  task automatic run_until_period(input int p, input int budget, input string tag);
    int c = 0;
    while (int'(cur_period) != p && c < budget) begin cycle(); c++; end
    if (int'(cur_period) != p) check_eq(tag, int'(cur_period), p);
  endtask

  initial begin
    int any_step;
    int c;
    model_reset();

    // Reset held for 3 clocks, then idle with enable low.
    repeat (3) cycle();
    check_eq("rst_step", int'(drv_step), 0);
    check_eq("rst_dir", int'(drv_dir), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_period", int'(cur_period), 250);
    check_eq("rst_cnt", int'(step_cnt), 0);
    rst = 1'b1;
    any_step = 0;
    repeat (1000) begin cycle(); if (drv_step) any_step = 1; end
    check_eq("idle_no_step", any_step, 0);

    // Acceleration to N=200.
    obs_q.delete();
    drv_enable_SM = 1'b1; N = PW'(200); dir_req = 1'b1;
    run_until_obs(15, 20000, "accel_timeout");
    check_eq("accel_cnt14", int'(step_cnt), 14);
    check_eq("accel_dir", int'(drv_dir), 1);
    run_until_obs(16, 2000, "cruise_timeout");
    for (int k = 1; k < 16 && k < obs_q.size(); k++)
      check_eq($sformatf("accel_len%0d", k), obs_q[k], (k <= 13) ? (254 - 4 * k) : 200);

    // Stop from cruise.
    obs_q.delete();
    drv_enable_SM = 1'b0;
    run_until_idle(20000, "stop_timeout");
    check_eq("stop_nper", obs_q.size(), 13);
    for (int j = 0; j < 13 && j < obs_q.size(); j++)
      check_eq($sformatf("decel_len%0d", j), obs_q[j], 200 + 4 * j);
    check_eq("stop_busy", int'(busy), 0);
    check_eq("stop_dir", int'(drv_dir), 1);

    // Direction reversal at cruise, one trig per clock.
    trig_div = 1;
    drv_enable_SM = 1'b1; N = PW'(200); dir_req = 1'b1;
    run_until_period(200, 6000, "rev_accel_timeout");
    dir_req = 1'b0;
    run_until_idle(6000, "rev_decel_timeout");
    check_eq("rev_dir_held", int'(drv_dir), 1);
    check_eq("rev_idle_step", int'(drv_step), 0);
    cycle();
    check_eq("rev_busy", int'(busy), 1);
    check_eq("rev_dir_new", int'(drv_dir), 0);
    check_eq("rev_period", int'(cur_period), 250);
    check_eq("rev_cnt", int'(step_cnt), 0);
    check_eq("rev_step", int'(drv_step), 1);

    // Clamp low, stop via N=0, clamp high.
    N = PW'(1);
    run_until_period(3, 12000, "clamp_low_timeout");
    repeat (30) cycle();
    check_eq("clamp_low", int'(cur_period), 3);
    N = '0;
    run_until_idle(12000, "n0_stop_timeout");
    check_eq("n0_period", int'(cur_period), 250);
    N = PW'(1000);
    repeat (600) cycle();
    check_eq("clamp_high", int'(cur_period), 250);
    check_eq("clamp_high_cnt", int'(step_cnt), 2);

    // Asynchronous reset in the middle of a pulse.
    trig_div = 5;
    c = 0;
    while (!drv_step && c < 3000) begin cycle(); c++; end
    check_eq("arst_pulse_seen", int'(drv_step), 1);
    #3 rst = 1'b0;
    #1;
    check_eq("arst_step", int'(drv_step), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_period", int'(cur_period), 250);
    check_eq("arst_cnt", int'(step_cnt), 0);
    prev_step = int'(drv_step);
    prev_dir  = int'(drv_dir);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    check_eq("restart_busy", int'(busy), 1);
    check_eq("restart_period", int'(cur_period), 250);
    check_eq("restart_cnt", int'(step_cnt), 0);
    check_eq("restart_step", int'(drv_step), 1);

    // Randomised requests with random trig.
    trig_div = 0;
    for (int s = 0; s < 40; s++) begin
      int r;
      drv_enable_SM = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) dir_req = ~dir_req;
      r = int'($urandom_range(0, 7));
      if (r == 0)      N = '0;
      else if (r == 1) N = PW'(1);
      else if (r == 2) N = PW'(1000);
      else             N = PW'($urandom_range(150, 260));
      repeat ($urandom_range(50, 400)) cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
